// File: rtl/npc_ras_unit.sv
// Next-PC / PC register unit for the multi-cycle MIPS core, with EPC and a
// circular return-address stack that is pushed on links and popped on returns.
module npc_ras_unit #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_we,
  input  logic [2:0]                   npc_op,
  input  logic [25:0]                  imm,
  input  logic                         link,
  input  logic [ADDR_W-1:0]            reg_target,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            pc_plus4,
  output logic [ADDR_W-1:0]            epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_hit,
  output logic                         ras_underflow,
  output logic                         ras_overflow,
  output logic                         misalign,
  output logic                         op_err
);

  localparam int AW = ADDR_W - 2;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_PLUS4  = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JR     = 3'd3,
    OP_RET    = 3'd4,
    OP_EXC    = 3'd5,
    OP_ERET   = 3'd6,
    OP_RSVD   = 3'd7
  } npc_op_e;

  npc_op_e         op;
  logic [AW-1:0]   pc_w;
  logic [AW-1:0]   seq_w;
  logic [AW-1:0]   next_w;
  logic [AW-1:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr, ptr_nx, top_ptr, wr_ptr;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            non_empty, full_now;
  logic            pop, push, ovf_set;
  logic            hit_nx, und_nx, mis_nx, operr_nx;

  assign op        = npc_op_e'(npc_op);
  assign seq_w     = pc_w + AW'(1);
  assign top_ptr   = ptr - PW'(1);
  assign non_empty = (cnt != '0);
  assign full_now  = (cnt == CW'(RAS_DEPTH));

  // A linked RET pops first, so its push lands on the slot the pop just freed.
  assign pop     = (op == OP_RET) && non_empty;
  assign push    = link && (op != OP_EXC) && (op != OP_RSVD);
  assign wr_ptr  = pop ? top_ptr : ptr;
  assign ovf_set = push && !pop && full_now;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_w   = seq_w;
    hit_nx   = 1'b0;
    und_nx   = 1'b0;
    mis_nx   = 1'b0;
    operr_nx = 1'b0;
    unique case (op)
      OP_PLUS4:  next_w = seq_w;
      OP_BRANCH: next_w = seq_w + AW'($signed(imm[15:0]));
      OP_JUMP:   next_w = (pc_w & ~AW'(26'h3FF_FFFF)) | AW'(imm);
      OP_JR: begin
        next_w = reg_target[ADDR_W-1:2];
        mis_nx = (reg_target[1:0] != 2'b00);
      end
      OP_RET: begin
        if (non_empty) begin
          next_w = ras_mem[top_ptr];
          hit_nx = 1'b1;
        end else begin
          next_w = reg_target[ADDR_W-1:2];
          und_nx = 1'b1;
          mis_nx = (reg_target[1:0] != 2'b00);
        end
      end
      OP_EXC:  next_w = EXC_VECTOR[ADDR_W-1:2];
      OP_ERET: next_w = epc[ADDR_W-1:2];
      OP_RSVD: begin
        next_w   = pc_w;
        operr_nx = 1'b1;
      end
      default: next_w = seq_w;
    endcase
  end

  always_comb begin
    ptr_nx = ptr;
    cnt_nx = cnt;
    if (push && !pop) begin
      ptr_nx = ptr + PW'(1);
      cnt_nx = full_now ? cnt : cnt + CW'(1);
    end else if (pop && !push) begin
      ptr_nx = top_ptr;
      cnt_nx = cnt - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_w          <= RESET_PC[ADDR_W-1:2];
      epc           <= '0;
      ptr           <= '0;
      cnt           <= '0;
      ras_hit       <= 1'b0;
      ras_underflow <= 1'b0;
      ras_overflow  <= 1'b0;
      misalign      <= 1'b0;
      op_err        <= 1'b0;
    end else if (pc_we) begin
      pc_w          <= next_w;
      if (op == OP_EXC) epc <= pc;
      ptr           <= ptr_nx;
      cnt           <= cnt_nx;
      ras_hit       <= hit_nx;
      ras_underflow <= und_nx;
      ras_overflow  <= ras_overflow | ovf_set;
      misalign      <= mis_nx;
      op_err        <= operr_nx;
    end else begin
      ras_hit       <= 1'b0;
      ras_underflow <= 1'b0;
      misalign      <= 1'b0;
      op_err        <= 1'b0;
    end
  end

  // NOTE: stack storage has no reset; validity is tracked by ptr/cnt alone.
  always_ff @(posedge clk) begin
    if (rst_n && pc_we && push) ras_mem[wr_ptr] <= seq_w;
  end

  assign pc        = {pc_w, 2'b00};
  assign pc_plus4  = {seq_w, 2'b00};
  assign ras_count = cnt;
  assign ras_empty = (cnt == '0);
  assign ras_full  = full_now;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Self-checking bench for npc_ras_unit: a behavioural model queues expected
// post-edge state for each driven cycle; it is popped and compared after the edge.
module tb_npc_ras_unit;

  localparam int D = 8;
  localparam logic [2:0] PLUS4 = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, JR = 3'd3,
                         RET = 3'd4, EXC = 3'd5, ERET = 3'd6, RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_we = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic [25:0] imm = '0;
  logic        link = 1'b0;
  logic [31:0] reg_target = '0;
  logic [31:0] pc, pc_plus4, epc;
  logic [3:0]  ras_count;
  logic        ras_empty, ras_full, ras_hit, ras_underflow, ras_overflow, misalign, op_err;

  npc_ras_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_we(pc_we), .npc_op(npc_op), .imm(imm),
    .link(link), .reg_target(reg_target), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_hit(ras_hit), .ras_underflow(ras_underflow), .ras_overflow(ras_overflow),
    .misalign(misalign), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] epc;
    logic [3:0]  cnt;
    logic        full, empty, hit, und, ovf, mis, operr;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model: a bounded queue instead of a circular buffer.
  logic [31:0] m_pc = 32'h0000_3000;
  logic [31:0] m_epc = '0;
  logic        m_ovf = 1'b0;
  logic [29:0] stk[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic [2:0] op,
                      input logic [25:0] im, input logic lk, input logic [31:0] rt);
    exp_t        e;
    logic [29:0] w, nw;
    logic        hit, und, mis, operr;
    w = m_pc[31:2]; nw = w; hit = 0; und = 0; mis = 0; operr = 0;
    if (!rst) begin
      m_pc = 32'h0000_3000; m_epc = '0; m_ovf = 0; stk.delete();
    end else if (we) begin
      case (op)
        PLUS4:  nw = w + 30'd1;
        BRANCH: nw = w + 30'd1 + {{14{im[15]}}, im[15:0]};
        JUMP:   nw = {w[29:26], im};
        JR:     begin nw = rt[31:2]; mis = (rt[1:0] != 0); end
        RET: begin
          if (stk.size() > 0) begin nw = stk.pop_back(); hit = 1; end
          else begin nw = rt[31:2]; und = 1; mis = (rt[1:0] != 0); end
        end
        EXC:    begin nw = 30'h0000_4180 >> 2; m_epc = m_pc; end
        ERET:   nw = m_epc[31:2];
        default: begin nw = w; operr = 1; end
      endcase
      if (lk && op != EXC && op != RSVD) begin
        if (stk.size() == D) begin void'(stk.pop_front()); m_ovf = 1; end
        stk.push_back(w + 30'd1);
      end
      m_pc = {nw, 2'b00};
    end
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.epc = m_epc; e.cnt = 4'(stk.size());
    e.full = (stk.size() == D); e.empty = (stk.size() == 0);
    e.hit = hit; e.und = und; e.ovf = m_ovf; e.mis = mis; e.operr = operr;
    exp_q.push_back(e);

    rst_n = rst; pc_we = we; npc_op = op; imm = im; link = lk; reg_target = rt;
    @(posedge clk);
    #1;
    rst_n = 1'b1; pc_we = 1'b0; link = 1'b0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      check("pc", 64'(pc), 64'(e.pc));
      check("pc_plus4", 64'(pc_plus4), 64'(e.pc4));
      check("epc", 64'(epc), 64'(e.epc));
      check("ras_count", 64'(ras_count), 64'(e.cnt));
      check("ras_full", 64'(ras_full), 64'(e.full));
      check("ras_empty", 64'(ras_empty), 64'(e.empty));
      check("ras_hit", 64'(ras_hit), 64'(e.hit));
      check("ras_underflow", 64'(ras_underflow), 64'(e.und));
      check("ras_overflow", 64'(ras_overflow), 64'(e.ovf));
      check("misalign", 64'(misalign), 64'(e.mis));
      check("op_err", 64'(op_err), 64'(e.operr));
    end
  endtask

  initial begin
    // Reset, sequential fetch and hold.
    step(0, 1, PLUS4, 0, 0, 0);
    check("reset_pc", 64'(pc), 64'h3000);
    repeat (3) step(1, 1, PLUS4, 0, 0, 0);
    check("seq_pc", 64'(pc), 64'h300C);
    repeat (2) step(1, 0, JUMP, 26'h3FF_FFFF, 1, 0);
    check("hold_pc", 64'(pc), 64'h300C);

    // Branch backwards and jump.
    step(1, 1, PLUS4, 0, 0, 0);
    step(1, 1, BRANCH, 26'h000_FFFC, 0, 0);
    check("branch_pc", 64'(pc), 64'h3004);
    step(1, 1, JUMP, 26'h000_0C40, 0, 0);
    check("jump_pc", 64'(pc), 64'h3100);
    step(1, 1, JR, 0, 0, 32'h0000_3102);

    // Link, return hit, then underflow with misaligned fallback.
    step(0, 1, PLUS4, 0, 0, 0);
    step(1, 1, JUMP, 26'h000_0C40, 1, 0);
    step(1, 1, RET, 0, 0, 32'h0);
    check("ret_hit_pc", 64'(pc), 64'h3004);
    step(1, 1, RET, 0, 0, 32'h0000_3203);
    check("ret_fallback_pc", 64'(pc), 64'h3200);

    // Overflow: nine linked jumps from distinct PCs, then drain.
    for (int i = 0; i < 9; i++) step(1, 1, JUMP, 26'(26'h0C10 + 16 * i), 1, 0);
    check("ovf_full", 64'(ras_full), 64'd1);
    for (int i = 0; i < 9; i++) step(1, 1, RET, 0, 0, 32'h0000_3000);

    // Linked RET on non-empty and empty stack; exception round trip.
    step(1, 1, JUMP, 26'h000_0C80, 1, 0);
    step(1, 1, RET, 0, 1, 32'h0);
    step(1, 1, RET, 0, 0, 32'h0);
    step(1, 1, RET, 0, 1, 32'h0000_3010);
    step(1, 1, JR, 0, 0, 32'h0000_3020);
    step(1, 1, EXC, 0, 1, 0);
    check("exc_pc", 64'(pc), 64'h4180);
    check("exc_epc", 64'(epc), 64'h3020);
    step(1, 1, ERET, 0, 0, 0);
    step(1, 1, RSVD, 0, 1, 0);
    step(1, 0, PLUS4, 0, 0, 0);

    // Reset mid-stack while committing.
    for (int i = 0; i < 5; i++) step(1, 1, JUMP, 26'(26'h0D00 + 8 * i), 1, 0);
    step(0, 1, PLUS4, 0, 1, 0);
    step(1, 1, RET, 0, 0, 32'h0000_3400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
